// File: rtl/cs42448_cfg_seq_if.sv
// Write-request handshake between the CS42448 config sequencer and an I2C write master.
interface cs42448_cfg_seq_if;
   logic       wr_req;
   logic [6:0] wr_dev_addr;
   logic [7:0] wr_reg_addr;
   logic [7:0] wr_data;
   logic       wr_ack;
   logic       wr_nack;

   modport master (output wr_req, wr_dev_addr, wr_reg_addr, wr_data, input wr_ack, wr_nack);
   modport slave  (input wr_req, wr_dev_addr, wr_reg_addr, wr_data, output wr_ack, wr_nack);
endinterface

// File: rtl/cs42448_cfg_seq.sv
// CS42448 power-up sequencer: pulses the codec reset, waits for power-up, then writes a
// fixed register table through an I2C write master with bounded retry on NACK/timeout.
module cs42448_cfg_seq #(
   parameter logic [6:0] DEV_ADDR        = 7'h48,
   parameter int         RST_CYCLES      = 1200,
   parameter int         PWR_WAIT_CYCLES = 12000,
   parameter int         ACK_TIMEOUT     = 65535,
   parameter int         MAX_RETRY       = 3,
   parameter int         RETRY_GAP       = 16
) (
   input  logic              sys_clk_i,
   input  logic              sys_rst_i,
   input  logic              start_i,
   output logic              codec_rst_n_o,
   output logic              busy_o,
   output logic              init_done_o,
   output logic              init_err_o,
   output logic [2:0]        err_index_o,
   cs42448_cfg_seq_if.master wr
);
   localparam int MAX_A   = (RST_CYCLES > PWR_WAIT_CYCLES) ? RST_CYCLES : PWR_WAIT_CYCLES;
   localparam int MAX_B   = (ACK_TIMEOUT > RETRY_GAP) ? ACK_TIMEOUT : RETRY_GAP;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int RW      = $clog2(MAX_RETRY + 1);
   localparam logic [2:0] LAST_IDX = 3'd5;

   typedef enum logic [3:0] {
      IDLE, RST_LOW, PWR_WAIT, WRITE, WAIT_ACK, GAP, NEXT, DONE, ERROR
   } state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q, err_idx_q;
   logic [RW-1:0] retry_q;
   logic          rst_n_q, busy_q, done_q, err_q, req_q;
   logic [6:0]    dev_q;
   logic [7:0]    reg_q, dat_q;
   logic          attempt_fail;

   // {MAP, data}; entry 5 powers the codec up and must stay last
   function automatic logic [15:0] cfg_entry(input logic [2:0] i);
      case (i)
         3'd0:    cfg_entry = 16'h02FF;
         3'd1:    cfg_entry = 16'h03F0;
         3'd2:    cfg_entry = 16'h0446;
         3'd3:    cfg_entry = 16'h051C;
         3'd4:    cfg_entry = 16'h0610;
         default: cfg_entry = 16'h0200;
      endcase
   endfunction

   // ack+nack together counts as a NACK; the WRITE cycle is the first timeout cycle
   assign attempt_fail = wr.wr_nack || (cnt_q >= CW'(ACK_TIMEOUT - 1));

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         retry_q   <= '0;
         err_idx_q <= '0;
         rst_n_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         req_q     <= 1'b0;
         dev_q     <= '0;
         reg_q     <= '0;
         dat_q     <= '0;
      end else begin
         case (state_q)
            IDLE, DONE, ERROR: if (start_i) begin
               state_q   <= RST_LOW;
               busy_q    <= 1'b1;
               done_q    <= 1'b0;
               err_q     <= 1'b0;
               err_idx_q <= '0;
               rst_n_q   <= 1'b0;
               idx_q     <= '0;
               retry_q   <= '0;
               cnt_q     <= '0;
            end
            RST_LOW: if (cnt_q == CW'(RST_CYCLES - 1)) begin
               state_q <= PWR_WAIT;
               rst_n_q <= 1'b1;
               cnt_q   <= '0;
            end else cnt_q <= cnt_q + 1'b1;
            PWR_WAIT: if (cnt_q == CW'(PWR_WAIT_CYCLES - 1)) begin
               state_q        <= WRITE;
               req_q          <= 1'b1;
               dev_q          <= DEV_ADDR;
               {reg_q, dat_q} <= cfg_entry(idx_q);
               cnt_q          <= '0;
            end else cnt_q <= cnt_q + 1'b1;
            WRITE: begin
               state_q <= WAIT_ACK;
               cnt_q   <= cnt_q + 1'b1;
            end
            WAIT_ACK: begin
               if (wr.wr_ack && !wr.wr_nack) begin
                  state_q <= NEXT;
                  req_q   <= 1'b0;
                  retry_q <= '0;
               end else if (attempt_fail) begin
                  req_q   <= 1'b0;
                  cnt_q   <= '0;
                  retry_q <= retry_q + 1'b1;
                  if (retry_q < RW'(MAX_RETRY - 1)) state_q <= GAP;
                  else begin
                     state_q   <= ERROR;
                     busy_q    <= 1'b0;
                     err_q     <= 1'b1;
                     err_idx_q <= idx_q;
                  end
               end else cnt_q <= cnt_q + 1'b1;
            end
            GAP: if (cnt_q == CW'(RETRY_GAP - 1)) begin
               state_q        <= WRITE;
               req_q          <= 1'b1;
               {reg_q, dat_q} <= cfg_entry(idx_q);
               cnt_q          <= '0;
            end else cnt_q <= cnt_q + 1'b1;
            NEXT: if (idx_q == LAST_IDX) begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else begin
               state_q        <= WRITE;
               idx_q          <= idx_q + 3'd1;
               req_q          <= 1'b1;
               {reg_q, dat_q} <= cfg_entry(idx_q + 3'd1);
               cnt_q          <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign codec_rst_n_o  = rst_n_q;
   assign busy_o         = busy_q;
   assign init_done_o    = done_q;
   assign init_err_o     = err_q;
   assign err_index_o    = err_idx_q;
   assign wr.wr_req      = req_q;
   assign wr.wr_dev_addr = dev_q;
   assign wr.wr_reg_addr = reg_q;
   assign wr.wr_data     = dat_q;
endmodule

// File: tb/tb_cs42448_cfg_seq.sv
// Bench for cs42448_cfg_seq: scripted I2C responder, scenario table, reset-abort sequence.
module tb_cs42448_cfg_seq;
   localparam int R = 4, P = 10, T = 20, MR = 2, G = 3, MAXW = 32;

   typedef enum int {R_ACK, R_NACK, R_BOTH, R_NONE} resp_e;
   typedef struct {
      int         f_idx;      // table index whose attempts fail
      resp_e      kind;       // how they fail
      int         f_cnt;      // number of failing attempts
      int         busy_start; // >0: extra start pulse this many cycles into the run
      logic       exp_done;
      logic       exp_err;
      logic [2:0] exp_eidx;
      int         exp_nwr;
   } scn_t;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic codec_rst_n, busy, init_done, init_err;
   logic [2:0] err_index;
   cs42448_cfg_seq_if wr();

   cs42448_cfg_seq #(.DEV_ADDR(7'h48), .RST_CYCLES(R), .PWR_WAIT_CYCLES(P),
                     .ACK_TIMEOUT(T), .MAX_RETRY(MR), .RETRY_GAP(G)) dut (
      .sys_clk_i(clk), .sys_rst_i(rst), .start_i(start), .codec_rst_n_o(codec_rst_n),
      .busy_o(busy), .init_done_o(init_done), .init_err_o(init_err),
      .err_index_o(err_index), .wr(wr));

   initial forever #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [15:0] exp_tbl [6];

   // responder / monitor state
   int    cyc = 0, n_wr = 0, codec_rise = -1, start_cyc = -1, lat = 0;
   int    m_idx = 0, m_att = 0, f_idx = 7, f_cnt = 0;
   resp_e f_kind = R_ACK, cur_resp = R_ACK;
   bit    new_run = 0, await_start = 0, m_ok = 1, prev_req = 0, prev_crst = 0;
   logic  codec_at_start = 1'b1;
   int    w_rise [MAXW], w_fall [MAXW], w_idx [MAXW];
   resp_e w_resp [MAXW];
   logic [22:0] w_fld [MAXW];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // I2C master model: responds 5 cycles after wr_req rises, per the scenario script
   initial begin
      wr.wr_ack = 1'b0; wr.wr_nack = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         wr.wr_ack = 1'b0; wr.wr_nack = 1'b0;
         if (await_start && start) begin
            start_cyc = cyc; codec_at_start = codec_rst_n; await_start = 0;
         end
         if (codec_rst_n && !prev_crst) codec_rise = cyc;
         prev_crst = codec_rst_n;
         if (wr.wr_req && !prev_req && n_wr < MAXW) begin
            if (new_run) begin m_idx = 0; m_att = 0; new_run = 0; end
            else if (m_ok) begin m_idx++; m_att = 0; end
            else m_att++;
            cur_resp = (m_idx == f_idx && m_att < f_cnt) ? f_kind : R_ACK;
            m_ok = (cur_resp == R_ACK);
            w_rise[n_wr] = cyc; w_fall[n_wr] = -1; w_idx[n_wr] = m_idx; w_resp[n_wr] = cur_resp;
            w_fld[n_wr] = {wr.wr_dev_addr, wr.wr_reg_addr, wr.wr_data};
            lat = 0; n_wr++;
         end else if (wr.wr_req) lat++;
         if (!wr.wr_req && prev_req && n_wr > 0) w_fall[n_wr-1] = cyc;
         if (wr.wr_req && lat == 4) begin
            case (cur_resp)
               R_ACK:   wr.wr_ack = 1'b1;
               R_NACK:  wr.wr_nack = 1'b1;
               R_BOTH:  begin wr.wr_ack = 1'b1; wr.wr_nack = 1'b1; end
               default: ;
            endcase
         end
         prev_req = wr.wr_req;
      end
   end

   task automatic pulse_start();
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_codec_rst_n"}, codec_rst_n, 0);
      chk({tag, "_wr_req"}, wr.wr_req, 0);
      chk({tag, "_wr_fields"}, {wr.wr_dev_addr, wr.wr_reg_addr, wr.wr_data}, 0);
      chk({tag, "_flags"}, {busy, init_done, init_err, err_index}, 0);
   endtask

   task automatic run_scn(input int id, input scn_t s);
      bit    to;
      int    nw;
      string tg;
      tg = $sformatf("s%0d", id);
      f_idx = s.f_idx; f_kind = s.kind; f_cnt = s.f_cnt;
      n_wr = 0; new_run = 1; codec_rise = -1; start_cyc = -1; await_start = 1;
      pulse_start();
      chk({tg, "_busy_run"}, busy, 1);
      if (s.busy_start > 0) begin
         repeat (s.busy_start) @(negedge clk);
         pulse_start();
      end
      to = 1;
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk); #2;
         if (!busy) begin to = 0; break; end
      end
      chk({tg, "_finish_bound"}, to, 0);
      repeat (20) @(negedge clk);
      #2;
      chk({tg, "_codec_low_at_start"}, codec_at_start, 0);
      chk({tg, "_rst_low_cycles"}, codec_rise - start_cyc, R);
      chk({tg, "_pwr_wait_cycles"}, w_rise[0] - codec_rise, P);
      chk({tg, "_init_done"}, init_done, s.exp_done);
      chk({tg, "_init_err"}, init_err, s.exp_err);
      chk({tg, "_err_index"}, err_index, s.exp_eidx);
      chk({tg, "_busy_end"}, busy, 0);
      chk({tg, "_codec_high_end"}, codec_rst_n, 1);
      chk({tg, "_write_count"}, n_wr, s.exp_nwr);
      nw = (n_wr < MAXW) ? n_wr : MAXW;
      for (int i = 0; i < nw; i++) begin
         chk($sformatf("%s_w%0d_fields", tg, i), w_fld[i], {7'h48, exp_tbl[w_idx[i]]});
         if (w_resp[i] == R_NONE)
            chk($sformatf("%s_w%0d_timeout_len", tg, i), w_fall[i] - w_rise[i], T);
         if (w_resp[i] != R_ACK && i + 1 < nw) begin
            chk($sformatf("%s_w%0d_retry_gap", tg, i), w_rise[i+1] - w_fall[i], G);
            chk($sformatf("%s_w%0d_retry_fields", tg, i), w_fld[i+1], w_fld[i]);
         end
      end
   endtask

   scn_t scn [6];

   initial begin
      bit to;
      exp_tbl = '{16'h02FF, 16'h03F0, 16'h0446, 16'h051C, 16'h0610, 16'h0200};
      scn[0] = '{7, R_ACK,  0, 0, 1'b1, 1'b0, 3'd0, 6};
      scn[1] = '{2, R_NACK, 1, 0, 1'b1, 1'b0, 3'd0, 7};
      scn[2] = '{3, R_NACK, 9, 0, 1'b0, 1'b1, 3'd3, 5};
      scn[3] = '{0, R_NONE, 9, 0, 1'b0, 1'b1, 3'd0, 2};
      scn[4] = '{1, R_BOTH, 1, 6, 1'b1, 1'b0, 3'd0, 7};
      scn[5] = '{4, R_BOTH, 9, 0, 1'b0, 1'b1, 3'd4, 6};

      repeat (3) @(negedge clk);
      #2 chk_reset_outputs("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #2 chk_reset_outputs("idle");

      for (int s = 0; s < 6; s++) run_scn(s, scn[s]);

      // abort with sys_rst while index 4 is waiting for its ack
      f_idx = 7; f_cnt = 0; n_wr = 0; new_run = 1; await_start = 1;
      pulse_start();
      to = 1;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk); #1;
         if (n_wr == 5) begin to = 0; break; end
      end
      chk("abort_reach_idx4", to, 0);
      repeat (2) @(negedge clk);
      #1 chk("abort_req_before", wr.wr_req, 1);
      rst = 1'b1;
      #1 chk_reset_outputs("abort");
      @(negedge clk); #1 rst = 1'b0;
      repeat (30) @(negedge clk);
      #2 chk("abort_no_new_write", n_wr, 5);
      chk_reset_outputs("abort_idle");

      run_scn(6, scn[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end
endmodule
